lcd_responder: RTL and testbench
================================

LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40, sys_clock cycles busy after any accepted write other than clear/home.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1600, busy cycles after clear/home; legal values are >= 32.
REQ-003 sys_clock  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 lcd_rs  input  1  register select from host (0 command/status, 1 data).
REQ-006 lcd_rw  input  1  direction from host (0 write, 1 read).
REQ-007 lcd_en  input  1  host strobe; a transfer completes on its falling edge.
REQ-008 lcd_data_in  input  8  host write bus.
REQ-009 lcd_data_out  output  8  read-return bus.
REQ-010 lcd_data_oe  output  1  high while synchronized en=1 and rw=1.
REQ-011 disp_addr  input  5  scan index into the display buffer (0-15 line 1, 16-31 line 2).
REQ-012 disp_char  output  8  buffer byte at disp_addr, combinational.
REQ-013 ddram_addr  output  7  current address counter.
REQ-014 busy  output  1  busy flag.
REQ-015 display_on  output  1  display-control D bit.
REQ-016 overrun  output  1  sticky flag: a write or data read arrived while busy.

Function
REQ-017 lcd_en, lcd_rs, lcd_rw and lcd_data_in SHALL pass through an identical 2-flop synchronizer; strobe = previous en_s2 AND NOT en_s2.
REQ-018 An accepted transfer SHALL update state on the 3rd rising edge after lcd_en falls; busy SHALL rise on that same edge.
REQ-019 Busy counter: loaded on accept; decrements each cycle; busy = (counter != 0). A strobe on the cycle the counter reads 0 is accepted.
REQ-020 Command write (rs=0, rw=0), decoded by highest set bit:
- 0x01: clear; fill buffer with 0x20 one entry per cycle, index 0..31 (32 cycles inside busy window); ddram_addr=0; increment mode set; busy CLEAR_CYCLES.
- 0x02-0x03: home; ddram_addr=0; busy CLEAR_CYCLES.
- 0x04-0x07: entry mode; bit1 = increment(1)/decrement(0); S bit ignored.
- 0x08-0x0F: display_on = bit2.
- 0x10-0x1F: cursor shift; bit2=1 advance address per REQ-023 increment, bit2=0 per decrement.
- 0x20-0x7F: function set / CGRAM address; no state change except busy.
- 0x80-0xFF: ddram_addr = data[6:0], stored as written.
REQ-021 Data write (rs=1, rw=0): address 0x00-0x0F writes index addr; 0x40-0x4F writes index 16+(addr-0x40); other addresses discard the byte; address then advances per entry mode.
REQ-022 Status read (rs=0, rw=1): lcd_data_out = {busy, ddram_addr}; permitted while busy; no state change, no busy load.
REQ-023 Address advance: increment is +1 mod 128 except 0x27->0x40 and 0x67->0x00; decrement is -1 mod 128 except 0x40->0x27 and 0x00->0x67.
REQ-024 Data read (rs=1, rw=1) when not busy: lcd_data_out = mapped buffer byte, 0x20 if unmapped; address advances on strobe; no busy load.
REQ-025 Data read while busy: lcd_data_out = 0x00; no address advance; overrun set.
REQ-026 Any write strobe while busy SHALL be discarded and SHALL set overrun; overrun clears only on reset.
REQ-027 lcd_data_out SHALL be 0x00 whenever lcd_data_oe=0.
REQ-028 A clear fill in progress SHALL not be disturbed by accepted reads or scan reads; disp_char reflects partial fill.

Reset
REQ-029 reset_n low SHALL immediately force: buffer all 0x20, ddram_addr 0, increment mode, display_on 0, busy counter 0, overrun 0, fill idle, synchronizers 0, lcd_data_oe 0, lcd_data_out 0x00.
REQ-030 Reset asserted mid-clear or mid-busy SHALL abort the operation; the block is ready (busy=0) on the first edge after release.

Verification
REQ-031 Reset, write cmd 0x80|0x05 then data 0x41 -> disp_char[5]=0x41, ddram_addr=0x06, busy high 40 cycles.
REQ-032 Set addr 0x27, write 0x58 -> ddram_addr=0x40, buffer unchanged; write 0x59 -> disp_char[16]=0x59.
REQ-033 Fill buffer, cmd 0x01, poll status -> bit7=1 for 1600 cycles then 0; all disp_char=0x20; ddram_addr=0.
REQ-034 Write data during busy window -> byte discarded, overrun=1, ddram_addr unchanged.
REQ-035 Entry mode 0x04, addr 0x00, write 0x5A -> disp_char[0]=0x5A, ddram_addr=0x67; status read returns 0x67 (busy 0).
REQ-036 Pulse reset_n 200 cycles into a clear -> busy=0, buffer 0x20, overrun 0 immediately.

Source files
------------

// File: rtl/lcd_responder.sv
// lcd_responder: models the host-facing side of an HD44780-style 2x16 character LCD.
// The host drives a slow, asynchronous rs/rw/en/data bus. This block synchronizes that
// bus, decodes commands and data transfers, and keeps a 32-byte display buffer that a
// scan engine reads through disp_addr/disp_char.
//
// Ports:
//   sys_clock, reset_n       clock and asynchronous active-low reset
//   lcd_rs, lcd_rw, lcd_en   host bus controls; a transfer completes on the falling edge of en
//   lcd_data_in              host write bus
//   lcd_data_out, lcd_data_oe read-return bus and its output enable
//   disp_addr, disp_char     scan port into the display buffer (combinational read)
//   ddram_addr               current address counter
//   busy                     busy flag
//   display_on               display-control D bit
//   overrun                  sticky flag: a write or data read arrived while busy
module lcd_responder #(
    parameter int unsigned BUSY_CYCLES  = 40,
    parameter int unsigned CLEAR_CYCLES = 1600
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] disp_addr,
    output logic [7:0] disp_char,
    output logic [6:0] ddram_addr,
    output logic       busy,
    output logic       display_on,
    output logic       overrun
);

    localparam int unsigned MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned BUF_DEPTH  = 32;
    localparam logic [7:0]  BLANK      = 8'h20;

    typedef enum logic {
        FILL_IDLE,
        FILL_RUN
    } fill_state_e;

    // Next address after one step. Line 1 runs 0x00..0x27 and line 2 runs 0x40..0x67;
    // stepping off the end of either line lands on the start of the other.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h40)      return 7'h27;
            else if (a == 7'h00) return 7'h67;
            else                 return a - 7'd1;
        end
    endfunction

    // Maps a DDRAM address to {visible, buffer index}. Only the first 16 cells of
    // each line are backed by the buffer.
    function automatic logic [5:0] addr_map(input logic [6:0] a);
        if (a[6:4] == 3'b000)      return {1'b1, 1'b0, a[3:0]};
        else if (a[6:4] == 3'b100) return {1'b1, 1'b1, a[3:0]};
        else                       return 6'd0;
    endfunction

    // Host bus synchronizer; en_s3_q is kept only to detect the falling edge.
    logic       en_s1_q, en_s2_q, en_s3_q;
    logic       rs_s1_q, rs_s2_q;
    logic       rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic       oe_q;

    // Architectural state.
    logic [6:0]       addr_q, addr_d;
    logic             inc_q, inc_d;
    logic             disp_on_q, disp_on_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    fill_state_e      fill_state_q, fill_state_d;
    logic [4:0]       fill_idx_q, fill_idx_d;
    logic [7:0]       buf_q [BUF_DEPTH];
    logic [7:0]       buf_d [BUF_DEPTH];

    logic       strobe;
    logic [5:0] cur_map;
    logic [7:0] rd_byte;

    assign strobe  = en_s3_q & ~en_s2_q;
    assign cur_map = addr_map(addr_q);
    assign rd_byte = cur_map[5] ? buf_q[cur_map[4:0]] : BLANK;

    // Synchronizer and output-enable register. oe_q tracks en_s2 & rw_s2 exactly.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            en_s3_q   <= 1'b0;
            rs_s1_q   <= 1'b0;
            rs_s2_q   <= 1'b0;
            rw_s1_q   <= 1'b0;
            rw_s2_q   <= 1'b0;
            data_s1_q <= 8'h00;
            data_s2_q <= 8'h00;
            oe_q      <= 1'b0;
        end else begin
            en_s1_q   <= lcd_en;
            en_s2_q   <= en_s1_q;
            en_s3_q   <= en_s2_q;
            rs_s1_q   <= lcd_rs;
            rs_s2_q   <= rs_s1_q;
            rw_s1_q   <= lcd_rw;
            rw_s2_q   <= rw_s1_q;
            data_s1_q <= lcd_data_in;
            data_s2_q <= data_s1_q;
            oe_q      <= en_s1_q & rw_s1_q;
        end
    end

    // State register.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= 7'h00;
            inc_q        <= 1'b1;
            disp_on_q    <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            fill_state_q <= FILL_IDLE;
            fill_idx_q   <= 5'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= BLANK;
            end
        end else begin
            addr_q       <= addr_d;
            inc_q        <= inc_d;
            disp_on_q    <= disp_on_d;
            overrun_q    <= overrun_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            fill_state_q <= fill_state_d;
            fill_idx_q   <= fill_idx_d;
            buf_q        <= buf_d;
        end
    end

    // Next-state: clear fill, then transfer decode on the strobe cycle.
    always_comb begin
        addr_d       = addr_q;
        inc_d        = inc_q;
        disp_on_d    = disp_on_q;
        overrun_d    = overrun_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        fill_state_d = fill_state_q;
        fill_idx_d   = fill_idx_q;
        buf_d        = buf_q;

        // Clear fill blanks one entry per cycle; it always finishes inside the
        // busy window, so no accepted write can collide with it.
        if (fill_state_q == FILL_RUN) begin
            buf_d[fill_idx_q] = BLANK;
            fill_idx_d        = fill_idx_q + 5'd1;
            if (fill_idx_q == 5'd31) begin
                fill_state_d = FILL_IDLE;
            end
        end

        if (strobe) begin
            if (!rw_s2_q) begin
                if (busy_q) begin
                    overrun_d = 1'b1;
                end else if (!rs_s2_q) begin
                    cnt_d = CNT_W'(BUSY_CYCLES);
                    casez (data_s2_q)
                        8'b1???????: addr_d = data_s2_q[6:0];
                        8'b01??????,
                        8'b001?????: ;
                        8'b0001????: addr_d = addr_step(addr_q, data_s2_q[2]);
                        8'b00001???: disp_on_d = data_s2_q[2];
                        8'b000001??: inc_d = data_s2_q[1];
                        8'b0000001?: begin
                            addr_d = 7'h00;
                            cnt_d  = CNT_W'(CLEAR_CYCLES);
                        end
                        8'b00000001: begin
                            addr_d       = 7'h00;
                            inc_d        = 1'b1;
                            cnt_d        = CNT_W'(CLEAR_CYCLES);
                            fill_state_d = FILL_RUN;
                            fill_idx_d   = 5'd0;
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = CNT_W'(BUSY_CYCLES);
                    if (cur_map[5]) begin
                        buf_d[cur_map[4:0]] = data_s2_q;
                    end
                    addr_d = addr_step(addr_q, inc_q);
                end
            end else if (rs_s2_q) begin
                // Data read: a busy read returns nothing and leaves the address alone.
                if (busy_q) begin
                    overrun_d = 1'b1;
                end else begin
                    addr_d = addr_step(addr_q, inc_q);
                end
            end
        end

        busy_d = (cnt_d != '0);
    end

    // Read-return mux; lcd_data_out is a fixed port name, so it stays a decode of
    // registered state rather than a register of its own.
    always_comb begin
        lcd_data_out = 8'h00;
        if (oe_q) begin
            if (!rs_s2_q)     lcd_data_out = {busy_q, addr_q};
            else if (!busy_q) lcd_data_out = rd_byte;
        end
    end

    assign lcd_data_oe = oe_q;
    assign disp_char   = buf_q[disp_addr];
    assign ddram_addr  = addr_q;
    assign busy        = busy_q;
    assign display_on  = disp_on_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Testbench for lcd_responder: directed host transfers with hand-computed expected
// values. Read returns are queued when a read is issued and compared by a monitor
// when lcd_data_oe drops; state outputs are checked directly after each step.
module tb_lcd_responder;

    logic       clk;
    logic       rst_n;
    logic       rs, rw, en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;
    logic [4:0] daddr;
    logic [7:0] dchar;
    logic [6:0] ddram;
    logic       busy;
    logic       don;
    logic       ovr;

    int tests;
    int fails;
    int n;
    logic       prev_oe;
    logic [7:0] last_out;
    logic [7:0] exp_q[$];
    logic [7:0] v;

    lcd_responder #(.BUSY_CYCLES(40), .CLEAR_CYCLES(1600)) dut (
        .sys_clock   (clk),
        .reset_n     (rst_n),
        .lcd_rs      (rs),
        .lcd_rw      (rw),
        .lcd_en      (en),
        .lcd_data_in (din),
        .lcd_data_out(dout),
        .lcd_data_oe (oe),
        .disp_addr   (daddr),
        .disp_char   (dchar),
        .ddram_addr  (ddram),
        .busy        (busy),
        .display_on  (don),
        .overrun     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic peek(input int idx, output logic [7:0] val);
        daddr = 5'(idx);
        #1;
        val = dchar;
    endtask

    // One host transfer; returns 1 ns after the edge on which the DUT accepts it.
    task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d);
        @(posedge clk); #1;
        rs = r_s; rw = r_w; din = d; en = 1'b1;
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        xfer(1'b0, 1'b0, d);
    endtask

    task automatic wr_data(input logic [7:0] d);
        xfer(1'b1, 1'b0, d);
    endtask

    task automatic rd_status(input logic [7:0] exp);
        exp_q.push_back(exp);
        xfer(1'b0, 1'b1, 8'h00);
    endtask

    task automatic rd_data(input logic [7:0] exp);
        exp_q.push_back(exp);
        xfer(1'b1, 1'b1, 8'h00);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", k);
        end
    endtask

    task automatic scan_blank(input string name);
        for (int i = 0; i < 32; i++) begin
            peek(i, v);
            chk(name, {8'(i), v}, {8'(i), 8'h20});
        end
    endtask

    // Read-return monitor: captures the bus while oe is high, compares on its fall.
    initial begin
        prev_oe  = 1'b0;
        last_out = 8'h00;
        forever begin
            @(negedge clk);
            if (oe) begin
                last_out = dout;
            end else begin
                if (dout !== 8'h00) begin
                    tests++;
                    fails++;
                    $display("FAIL dout_idle: got 0x%0h expected 0x00", dout);
                end
                if (prev_oe) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL read_unexpected: got 0x%0h expected no read", last_out);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (last_out !== e) begin
                            fails++;
                            $display("FAIL read_return: got 0x%0h expected 0x%0h", last_out, e);
                        end
                    end
                end
            end
            prev_oe = oe;
        end
    end

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; rs = 1'b0; rw = 1'b0; en = 1'b0; din = 8'h00; daddr = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_ddram", 16'(ddram), 16'h00);
        chk("rst_display_on", 16'(don), 16'h0);
        chk("rst_overrun", 16'(ovr), 16'h0);
        chk("rst_oe", 16'(oe), 16'h0);
        chk("rst_dout", 16'(dout), 16'h00);
        peek(0, v); chk("rst_char0", 16'(v), 16'h20);
        @(posedge clk); #1 rst_n = 1'b1;

        // Address set then data write; busy lasts 40 cycles.
        wr_cmd(8'h85); wait_idle();
        wr_data(8'h41);
        n = 0;
        while (busy && n < 200) begin n++; @(posedge clk); #1; end
        chk("busy_40", 16'(n), 16'd40);
        peek(5, v); chk("char5", 16'(v), 16'h41);
        chk("ddram_06", 16'(ddram), 16'h06);

        // Display control.
        wr_cmd(8'h0C); wait_idle();
        chk("display_on_1", 16'(don), 16'h1);
        wr_cmd(8'h08); wait_idle();
        chk("display_on_0", 16'(don), 16'h0);

        // Line wrap 0x27 -> 0x40; byte at unmapped 0x27 is dropped.
        wr_cmd(8'hA7); wait_idle();
        wr_data(8'h58); wait_idle();
        chk("wrap_27_40", 16'(ddram), 16'h40);
        peek(16, v); chk("char16_unchanged", 16'(v), 16'h20);
        peek(15, v); chk("char15_unchanged", 16'(v), 16'h20);
        wr_data(8'h59); wait_idle();
        peek(16, v); chk("char16", 16'(v), 16'h59);
        chk("ddram_41", 16'(ddram), 16'h41);

        // Data reads advance the address and do not load busy.
        wr_cmd(8'hC0); wait_idle();
        rd_data(8'h59);
        chk("rd_no_busy", 16'(busy), 16'h0);
        chk("rd_adv_41", 16'(ddram), 16'h41);
        rd_data(8'h20);
        chk("rd_adv_42", 16'(ddram), 16'h42);
        wr_cmd(8'hA0); wait_idle();
        rd_data(8'h20);
        chk("rd_unmapped_adv", 16'(ddram), 16'h21);

        // Cursor shift both ways, and increment wrap 0x67 -> 0x00.
        wr_cmd(8'h14); wait_idle();
        chk("shift_right", 16'(ddram), 16'h22);
        wr_cmd(8'h10); wait_idle();
        chk("shift_left", 16'(ddram), 16'h21);
        wr_cmd(8'hE7); wait_idle();
        wr_cmd(8'h14); wait_idle();
        chk("wrap_67_00", 16'(ddram), 16'h00);

        // Data read while busy returns 0x00, keeps address, sets overrun.
        wr_cmd(8'h83); wait_idle();
        wr_data(8'h31);
        rd_data(8'h00);
        chk("rd_busy_overrun", 16'(ovr), 16'h1);
        chk("rd_busy_addr", 16'(ddram), 16'h04);
        wait_idle();

        // Reset in the middle of a busy window.
        wr_data(8'h33);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midbusy_busy", 16'(busy), 16'h0);
        chk("midbusy_overrun", 16'(ovr), 16'h0);
        chk("midbusy_ddram", 16'(ddram), 16'h00);
        peek(4, v); chk("midbusy_char4", 16'(v), 16'h20);
        peek(3, v); chk("midbusy_char3", 16'(v), 16'h20);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("midbusy_ready", 16'(busy), 16'h0);

        // Write while busy is discarded.
        wr_cmd(8'h83); wait_idle();
        wr_data(8'h31);
        wr_data(8'h32);
        chk("wr_busy_overrun", 16'(ovr), 16'h1);
        chk("wr_busy_addr", 16'(ddram), 16'h04);
        peek(3, v); chk("wr_busy_char3", 16'(v), 16'h31);
        peek(4, v); chk("wr_busy_char4", 16'(v), 16'h20);
        wait_idle();

        // Decrement mode wrap 0x00 -> 0x67, and 0x40 -> 0x27.
        wr_cmd(8'h04); wait_idle();
        wr_cmd(8'h80); wait_idle();
        wr_data(8'h5A);
        peek(0, v); chk("dec_char0", 16'(v), 16'h5A);
        chk("dec_wrap_67", 16'(ddram), 16'h67);
        wait_idle();
        rd_status(8'h67);
        wr_cmd(8'hC0); wait_idle();
        wr_cmd(8'h10); wait_idle();
        chk("shift_40_27", 16'(ddram), 16'h27);

        // Clear: partial fill is visible, status polls busy, busy lasts 1600 cycles.
        wr_cmd(8'hCF); wait_idle();
        wr_data(8'h7A); wait_idle();
        wr_cmd(8'h01);
        fork
            begin
                n = 0;
                while (busy && n < 4000) begin n++; @(posedge clk); #1; end
            end
            begin
                chk("clr_ddram", 16'(ddram), 16'h00);
                repeat (4) @(posedge clk);
                #1;
                peek(0, v);  chk("clr_partial_0", 16'(v), 16'h20);
                peek(31, v); chk("clr_partial_31", 16'(v), 16'h7A);
                rd_status(8'h80);
            end
        join
        chk("busy_1600", 16'(n), 16'd1600);
        rd_status(8'h00);
        scan_blank("clr_blank");
        wr_data(8'h41); wait_idle();
        chk("clr_inc_mode", 16'(ddram), 16'h01);

        // Reset 200 cycles into a clear.
        wr_cmd(8'h0C); wait_idle();
        wr_cmd(8'h01);
        wr_data(8'h55);
        chk("clr_overrun", 16'(ovr), 16'h1);
        repeat (192) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_clr_busy", 16'(busy), 16'h0);
        chk("rst_clr_overrun", 16'(ovr), 16'h0);
        chk("rst_clr_display", 16'(don), 16'h0);
        scan_blank("rst_clr_blank");
        @(posedge clk); #1 rst_n = 1'b1;
        chk("rst_clr_ready", 16'(busy), 16'h0);
        wr_data(8'h42);
        peek(0, v); chk("post_rst_char0", 16'(v), 16'h42);
        chk("post_rst_overrun", 16'(ovr), 16'h0);
        wait_idle();

        repeat (4) @(posedge clk);
        chk("reads_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
